// File: rtl/mezclador_bandas.sv
// mezclador_bandas: weights the three equalizer bands by their signed gains,
// sums them with one shared multiplier (one band per clock) and saturates the
// Q8.16 result. One sample is processed per enable strobe.
//
// Handshake: enable is a one-cycle strobe, accepted only when Busy=0 (IDLE).
// A strobe seen while Busy=1 is dropped and latches Muestra_Perdida until reset.
// Data_Valid pulses for one cycle when Data_Out updates, and Saturado is
// qualified by Data_Valid.
module mezclador_bandas #(
    parameter int N        = 25,
    parameter int S        = 1,
    parameter int Magnitud = 8,
    parameter int Decimal  = 16
) (
    input  logic         clock_In,
    input  logic         Reset,
    input  logic         enable,
    input  logic [N-1:0] Data_In_bajos,
    input  logic [N-1:0] Data_In_medios,
    input  logic [N-1:0] Data_In_altos,
    input  logic [N-1:0] Gain_bajos,
    input  logic [N-1:0] Gain_medios,
    input  logic [N-1:0] Gain_altos,
    output logic [N-1:0] Data_Out,
    output logic         Data_Valid,
    output logic         Busy,
    output logic         Saturado,
    output logic         Muestra_Perdida,
    output logic [2:0]   estado
);

    // Fractional shift; falls back to N-S-Magnitud if the field widths disagree.
    localparam int SHIFT = (S + Magnitud + Decimal == N) ? Decimal : (N - S - Magnitud);
    // Two guard bits: the sum of three full products can never wrap.
    localparam int AW    = 2 * N + 2;
    localparam int RW    = AW - SHIFT;
    localparam logic signed [RW-1:0] R_MAX = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [RW-1:0] R_MIN = {{(RW-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_B = 3'd1,
        MUL_M = 3'd2,
        MUL_A = 3'd3,
        SAT   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [N-1:0] lat_b, lat_m, lat_a, lat_gb, lat_gm, lat_ga;
    logic signed [N-1:0]    op_a, op_b;
    logic signed [2*N-1:0]  ext_a, ext_b, prod;
    logic signed [AW-1:0]   prod_ext, acc;
    logic signed [RW-1:0]   r;
    logic                   accept;

    assign accept = (state == IDLE) && enable;
    assign Busy   = (state != IDLE);
    assign estado = state;

    // State register.
    always_ff @(posedge clock_In or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: fixed walk through the three products and the saturate step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = MUL_B;
            MUL_B:   state_next = MUL_M;
            MUL_M:   state_next = MUL_A;
            MUL_A:   state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand multiplexer feeding the single shared multiplier.
    always_comb begin
        op_a = lat_b;
        op_b = lat_gb;
        case (state)
            MUL_M: begin op_a = lat_m; op_b = lat_gm; end
            MUL_A: begin op_a = lat_a; op_b = lat_ga; end
            default: ;
        endcase
    end

    // Sign-extend to the product width so the low 2N bits are the exact signed product.
    assign ext_a    = {{N{op_a[N-1]}}, op_a};
    assign ext_b    = {{N{op_b[N-1]}}, op_b};
    assign prod     = ext_a * ext_b;
    assign prod_ext = {{2{prod[2*N-1]}}, prod};

    // Dropping the low SHIFT bits of a signed value is an arithmetic shift (floor).
    assign r = $signed(acc[AW-1:SHIFT]);

    // Operand capture on an accepted strobe; later input changes are ignored.
    always_ff @(posedge clock_In or negedge Reset) begin
        if (!Reset) begin
            lat_b  <= '0; lat_m  <= '0; lat_a  <= '0;
            lat_gb <= '0; lat_gm <= '0; lat_ga <= '0;
        end else if (accept) begin
            lat_b  <= Data_In_bajos;
            lat_m  <= Data_In_medios;
            lat_a  <= Data_In_altos;
            lat_gb <= Gain_bajos;
            lat_gm <= Gain_medios;
            lat_ga <= Gain_altos;
        end
    end

    // Accumulator: the low-band product restarts it, the other two add in.
    always_ff @(posedge clock_In or negedge Reset) begin
        if (!Reset) begin
            acc <= '0;
        end else begin
            case (state)
                MUL_B:   acc <= prod_ext;
                MUL_M,
                MUL_A:   acc <= acc + prod_ext;
                default: ;
            endcase
        end
    end

    // Saturating output stage; Data_Out holds between samples.
    always_ff @(posedge clock_In or negedge Reset) begin
        if (!Reset) begin
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            Saturado   <= 1'b0;
        end else begin
            Data_Valid <= (state == SAT);
            Saturado   <= 1'b0;
            if (state == SAT) begin
                if (r > R_MAX) begin
                    Data_Out <= {1'b0, {(N-1){1'b1}}};
                    Saturado <= 1'b1;
                end else if (r < R_MIN) begin
                    Data_Out <= {1'b1, {(N-1){1'b0}}};
                    Saturado <= 1'b1;
                end else begin
                    Data_Out <= r[N-1:0];
                end
            end
        end
    end

    // Sticky lost-sample flag: any strobe outside IDLE is dropped.
    always_ff @(posedge clock_In or negedge Reset) begin
        if (!Reset)                Muestra_Perdida <= 1'b0;
        else if (enable && Busy)   Muestra_Perdida <= 1'b1;
    end

endmodule

// File: tb/tb_mezclador_bandas.sv
// Directed bench for mezclador_bandas: a vector table run through the full
// five-clock sequence, plus hand-written collision and mid-operation reset cases.
module tb_mezclador_bandas;

    localparam int N = 25;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] d_b, d_m, d_a, g_b, g_m, g_a;
    logic [N-1:0] data_out;
    logic         data_valid, busy, saturado, perdida;
    logic [2:0]   estado;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic [N-1:0] b, m, a, gb, gm, ga;
        logic [N-1:0] exp_out;
        logic         exp_sat;
    } vec_t;

    vec_t vecs[11];

    mezclador_bandas dut (
        .clock_In        (clk),
        .Reset           (rst_n),
        .enable          (enable),
        .Data_In_bajos   (d_b),
        .Data_In_medios  (d_m),
        .Data_In_altos   (d_a),
        .Gain_bajos      (g_b),
        .Gain_medios     (g_m),
        .Gain_altos      (g_a),
        .Data_Out        (data_out),
        .Data_Valid      (data_valid),
        .Busy            (busy),
        .Saturado        (saturado),
        .Muestra_Perdida (perdida),
        .estado          (estado)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input vec_t v);
        d_b = v.b; d_m = v.m; d_a = v.a;
        g_b = v.gb; g_m = v.gm; g_a = v.ga;
    endtask

    task automatic scramble();
        d_b = 25'($urandom_range(0, 33554431));
        d_m = 25'($urandom_range(0, 33554431));
        d_a = 25'($urandom_range(0, 33554431));
        g_b = 25'($urandom_range(0, 33554431));
        g_m = 25'($urandom_range(0, 33554431));
        g_a = 25'($urandom_range(0, 33554431));
    endtask

    // Full sample: accept at E0, expect valid result after E4, hold after E5.
    task automatic run_vec(input vec_t v);
        drive(v);
        enable = 1'b1;
        tick();                       // E0
        enable = 1'b0;
        scramble();
        chk({v.name, " busy_e0"}, busy, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk({v.name, " early_valid"}, data_valid, 0);
        end
        chk({v.name, " busy_e3"}, busy, 1);
        tick();                       // E4
        chk({v.name, " valid"}, data_valid, 1);
        chk({v.name, " out"}, data_out, v.exp_out);
        chk({v.name, " sat"}, saturado, v.exp_sat);
        chk({v.name, " busy_e4"}, busy, 0);
        tick();                       // E5
        chk({v.name, " valid_drop"}, data_valid, 0);
        chk({v.name, " sat_drop"}, saturado, 0);
        chk({v.name, " hold"}, data_out, v.exp_out);
    endtask

    initial begin : main
        int pulses;
        vec_t v;

        vecs[0]  = '{"unity",    25'h0010000, 25'h0008000, 25'h0004000, 25'h0010000, 25'h0010000, 25'h0010000, 25'h001C000, 1'b0};
        vecs[1]  = '{"pos_clip", 25'h0C80000, 25'h0123456, 25'h1ABCDEF, 25'h0020000, 25'h0000000, 25'h0000000, 25'h0FFFFFF, 1'b1};
        vecs[2]  = '{"neg_clip", 25'h1380000, 25'h0077777, 25'h0033333, 25'h0020000, 25'h0000000, 25'h0000000, 25'h1000000, 1'b1};
        vecs[3]  = '{"floor_neg",25'h1FFFFFF, 25'h0010000, 25'h0010000, 25'h0008000, 25'h0000000, 25'h0000000, 25'h1FFFFFF, 1'b0};
        vecs[4]  = '{"floor_pos",25'h0000001, 25'h0010000, 25'h0010000, 25'h0008000, 25'h0000000, 25'h0000000, 25'h0000000, 1'b0};
        vecs[5]  = '{"mixed",    25'h0020000, 25'h0030000, 25'h1FFC000, 25'h1FF0000, 25'h0008000, 25'h0020000, 25'h1FF0000, 1'b0};
        vecs[6]  = '{"at_max",   25'h0FFFFFF, 25'h0000000, 25'h0000000, 25'h0010000, 25'h0010000, 25'h0010000, 25'h0FFFFFF, 1'b0};
        vecs[7]  = '{"at_min",   25'h1000000, 25'h0000000, 25'h0000000, 25'h0010000, 25'h0010000, 25'h0010000, 25'h1000000, 1'b0};
        vecs[8]  = '{"over_max", 25'h0FFFFFF, 25'h0000001, 25'h0000000, 25'h0010000, 25'h0010000, 25'h0010000, 25'h0FFFFFF, 1'b1};
        vecs[9]  = '{"under_min",25'h1000000, 25'h0000000, 25'h1FFFFFF, 25'h0010000, 25'h0010000, 25'h0010000, 25'h1000000, 1'b1};
        vecs[10] = '{"cancel",   25'h0C80000, 25'h0C80000, 25'h0010000, 25'h0020000, 25'h1FE0000, 25'h0010000, 25'h0010000, 1'b0};

        rst_n  = 1'b0;
        enable = 1'b0;
        scramble();
        tick();
        tick();
        chk("rst_out",     data_out, 0);
        chk("rst_valid",   data_valid, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_sat",     saturado, 0);
        chk("rst_perdida", perdida, 0);
        chk("rst_state",   estado, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
            tick();
        end
        chk("no_loss_in_table", perdida, 0);

        // Busy collision: strobes at E2 and E4 must be dropped.
        pulses = 0;
        drive(vecs[0]);
        enable = 1'b1;
        tick();                       // E0
        enable = 1'b0;
        scramble();
        tick();                       // E1
        pulses += data_valid;
        enable = 1'b1;
        scramble();
        tick();                       // E2
        pulses += data_valid;
        chk("coll_perdida_e2", perdida, 1);
        chk("coll_busy_e2", busy, 1);
        enable = 1'b0;
        tick();                       // E3
        pulses += data_valid;
        enable = 1'b1;
        scramble();
        tick();                       // E4
        pulses += data_valid;
        chk("coll_out", data_out, 25'h001C000);
        chk("coll_valid", data_valid, 1);
        drive(vecs[5]);
        enable = 1'b1;
        tick();                       // E5: accepted
        pulses += data_valid;
        enable = 1'b0;
        scramble();
        chk("coll_e5_busy", busy, 1);
        chk("coll_one_pulse", pulses, 1);
        for (int k = 1; k <= 3; k++) tick();
        tick();
        chk("coll_next_valid", data_valid, 1);
        chk("coll_next_out", data_out, 25'h1FF0000);
        chk("coll_perdida_sticky", perdida, 1);
        tick();

        // Reset between E2 and E3 aborts the sample.
        drive(vecs[0]);
        enable = 1'b1;
        tick();                       // E0
        enable = 1'b0;
        tick();                       // E1
        tick();                       // E2
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_out", data_out, 0);
        chk("abort_perdida", perdida, 0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            pulses += data_valid;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_out_after", data_out, 0);
        chk("abort_busy_after", busy, 0);

        v = vecs[5];
        v.name = "after_abort";
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mezclador_bandas.md
Name: mezclador_bandas

Overview:
- Recombines the three equalizer band outputs (bajos, medios, altos) from the filter stage into a single audio sample.
- Applies a per-band signed gain to each band, sums the three weighted bands, and saturates the result.
- Uses one time-multiplexed multiplier driven by a small FSM, processing one sample per enable strobe.
- Sits directly downstream of the band-split filter bank. It drives the output/DAC path.

Parameters:
- N, 25, total word width: signed two's-complement fixed point.
- S, 1, sign bits.
- Magnitud, 8, integer bits.
- Decimal, 16, fractional bits (Q8.16). The value 1.0 is 25'h0010000.

Ports:
- clock_In  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  one-cycle sample strobe, aligned with the filter outputs.
- Data_In_bajos  input  N  low-band sample, Q8.16.
- Data_In_medios  input  N  mid-band sample, Q8.16.
- Data_In_altos  input  N  high-band sample, Q8.16.
- Gain_bajos  input  N  low-band gain, Q8.16 signed.
- Gain_medios  input  N  mid-band gain, Q8.16 signed.
- Gain_altos  input  N  high-band gain, Q8.16 signed.
- Data_Out  output  N  mixed, saturated sample, Q8.16.
- Data_Valid  output  1  one-cycle pulse when Data_Out updates.
- Busy  output  1  high while a sample is being processed.
- Saturado  output  1  high together with Data_Valid when the result was clipped.
- Muestra_Perdida  output  1  sticky flag: an enable arrived while Busy. Cleared only by Reset.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - Accumulator, latched operands, Data_Out, Data_Valid, Busy, Saturado and Muestra_Perdida all go to 0.
  - A reset mid-operation aborts the sample: no Data_Valid pulse is produced, and Data_Out stays 0.
- States: IDLE -> MUL_B -> MUL_M -> MUL_A -> SAT -> IDLE.
- IDLE:
  - On an edge E0 with enable=1, latch all six data/gain inputs into internal registers and go to MUL_B.
  - Inputs may change after E0.
- MUL_B (edge E1): acc <= Data_In_bajos x Gain_bajos, as a full 2N-bit signed product. Next state MUL_M.
- MUL_M (edge E2): acc <= acc + medios product. Next state MUL_A.
- MUL_A (edge E3): acc <= acc + altos product. Next state SAT.
- Accumulator width is 2N+2 bits, so the sum never wraps internally.
- SAT (edge E4):
  - Compute r = acc >>> Decimal (arithmetic shift, floor toward minus infinity).
  - If r > 2^(N-1)-1, then Data_Out <= 25'h0FFFFFF and Saturado=1.
  - If r < -2^(N-1), then Data_Out <= 25'h1000000 and Saturado=1.
  - Otherwise Data_Out <= r[N-1:0] and Saturado=0.
  - Data_Valid=1 for exactly the one cycle following E4. Next state IDLE.
- Latency: Data_Out and Data_Valid update at E4, i.e. 4 clocks after the accepting edge.
- Busy is 1 from after E0 through E4 inclusive, and 0 in IDLE.
- Throughput: one sample per 5 clocks at most.
  - The earliest next accepted enable is at the edge after E4.
  - An enable sampled at E4 itself is treated as a busy enable.
- enable while Busy=1: ignored (no latch, the sample in progress is unaffected), and Muestra_Perdida is set to 1 and held.
- Saturado is 0 whenever Data_Valid=0.
- Data_Out holds its last value between samples.
- Only one multiplier is instantiated. It is shared across the three MUL states through an operand multiplexer.

Test Plan:
- Unity mix:
  - Stimulus: bajos=25'h0010000 (1.0), medios=25'h0008000 (0.5), altos=25'h0004000 (0.25), all gains 25'h0010000, one enable.
  - Required: Data_Out=25'h001C000 (1.75), Data_Valid pulses exactly 4 clocks after enable, Saturado=0, Busy high for 4 cycles.
- Positive clip:
  - Stimulus: bajos=200.0 (25'h0C80000), Gain_bajos=2.0 (25'h0020000), other gains 0.
  - Required: Data_Out=25'h0FFFFFF, Saturado=1 coincident with Data_Valid.
- Negative clip:
  - Stimulus: bajos=-200.0 (25'h1380000), Gain_bajos=2.0, other gains 0.
  - Required: Data_Out=25'h1000000, Saturado=1.
- Floor rounding:
  - Stimulus: bajos=25'h1FFFFFF (-1 LSB), Gain_bajos=0.5 (25'h0008000), other gains 0.
  - Required: Data_Out=25'h1FFFFFF.
  - Same case with bajos=+1 LSB -> Data_Out=0.
- Busy collision:
  - Stimulus: enable at E0, then enable again at E2 and at E4.
  - Required: both later strobes are ignored, Muestra_Perdida=1 and stays 1, exactly one Data_Valid pulse, result equals the E0 operands.
  - A subsequent enable at E5 is accepted normally.
- Reset mid-operation:
  - Stimulus: enable at E0, drive Reset=0 between E2 and E3, release, then wait 10 clocks.
  - Required: Data_Valid never pulses, Data_Out=0, Busy=0, Muestra_Perdida=0.
  - The next enable yields a correct result.
